// File: rtl/core_gen2.sv
// rtl/core_gen2.sv - parametrised accumulator core with carry, SUB/SHR and stalling I/O handshakes
//
// Executes one instruction per cycle. The instruction comes from an external PROM that is addressed by PC.
// Instruction format: {op[3:0], field[FIELD_W-1:0]}.
// Ports:
//   CLK, RST             clock (rising edge) and synchronous active-high reset
//   PC                   registered instruction address to the PROM
//   INSTR                current instruction, combinationally valid for PC
//   IN_DATA/IN_VALID     input port; IN_READY is high while an IN instruction is waiting
//   OUT_DATA/OUT_VALID   output port; OUT_DATA always shows ACC, OUT_VALID is high during OUT
//   OUT_READY            sink acceptance for OUT
module core_gen2 #(
  parameter int DATA_W  = 4,
  parameter int PC_W    = 7,
  parameter int REG_N   = 8,
  parameter int FIELD_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic [PC_W-1:0]      PC,
  input  logic [FIELD_W+3:0]   INSTR,
  input  logic [DATA_W-1:0]    IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [DATA_W-1:0]    OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  localparam int REG_W = $clog2(REG_N);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD  = 4'h4, OP_ADDI = 4'h5, OP_SUB = 4'h6, OP_AND = 4'h7,
    OP_OR   = 4'h8, OP_XOR = 4'h9, OP_SHR = 4'hA, OP_IN  = 4'hB,
    OP_OUT  = 4'hC, OP_BRZ = 4'hD, OP_BRC = 4'hE, OP_JMP = 4'hF
  } op_t;

  logic [DATA_W-1:0] acc;
  logic              carry;
  logic [DATA_W-1:0] regs [REG_N];

  op_t               op;
  logic [FIELD_W-1:0] field;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   tgt;
  logic [REG_W-1:0]  r_idx;
  logic [DATA_W-1:0] rd;

  logic [PC_W-1:0]   pc_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic              c_nxt;
  logic              reg_we;

  // Field bits above the widest decoded slice are don't-care.
  logic              unused_field;

  assign op     = op_t'(INSTR[FIELD_W+3:FIELD_W]);
  assign field  = INSTR[FIELD_W-1:0];
  assign imm    = field[DATA_W-1:0];
  assign tgt    = field[PC_W-1:0];
  assign r_idx  = field[REG_W-1:0];
  assign rd     = regs[r_idx];
  assign unused_field = &{1'b0, field};

  assign IN_READY  = !RST && (op == OP_IN);
  assign OUT_VALID = !RST && (op == OP_OUT);
  assign OUT_DATA  = acc;

  always_comb begin
    pc_nxt  = PC + PC_ONE;
    acc_nxt = acc;
    c_nxt   = carry;
    reg_we  = 1'b0;
    unique case (op)
      OP_NOP:  ;
      OP_LDI:  acc_nxt = imm;
      OP_LD:   acc_nxt = rd;
      OP_ST:   reg_we  = 1'b1;
      OP_ADD:  {c_nxt, acc_nxt} = {1'b0, acc} + {1'b0, rd};
      OP_ADDI: {c_nxt, acc_nxt} = {1'b0, acc} + {1'b0, imm};
      OP_SUB: begin
        acc_nxt = acc - rd;
        c_nxt   = (rd > acc);
      end
      OP_AND:  acc_nxt = acc & rd;
      OP_OR:   acc_nxt = acc | rd;
      OP_XOR:  acc_nxt = acc ^ rd;
      OP_SHR: begin
        acc_nxt = acc >> 1;
        c_nxt   = acc[0];
      end
      // I/O stalls hold PC until the handshake completes.
      OP_IN: begin
        if (IN_VALID) acc_nxt = IN_DATA;
        else          pc_nxt  = PC;
      end
      OP_OUT: begin
        if (!OUT_READY) pc_nxt = PC;
      end
      // Branch conditions look at ACC/C as left by the previous instruction.
      OP_BRZ:  if (acc == '0) pc_nxt = tgt;
      OP_BRC:  if (carry)     pc_nxt = tgt;
      OP_JMP:  pc_nxt = tgt;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      PC    <= pc_nxt;
      acc   <= acc_nxt;
      carry <= c_nxt;
      if (reg_we) regs[r_idx] <= acc;
    end
  end

endmodule
